// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
//   IMEM_WORD_W : width of one imem word.
//   ldr_state_e : loader FSM state codes (3-bit).
package imem_loader_pkg;

  localparam int IMEM_WORD_W = 32;

  typedef enum logic [2:0] {
    LDR_IDLE  = 3'd0,
    LDR_LEN0  = 3'd1,
    LDR_LEN1  = 3'd2,
    LDR_DATA  = 3'd3,
    LDR_CHK   = 3'd4,
    LDR_DONE  = 3'd5,
    LDR_ERROR = 3'd6
  } ldr_state_e;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs a little-endian byte stream into 32-bit words.
// Ports:
//   clk, reset : clock and synchronous active-high reset.
//   clear      : restarts the byte index at 0 without writing a word.
//   vld_p0     : byte accepted this cycle.
//   byte_p0    : accepted byte.
//   vld_p1     : one-cycle pulse, the cycle after the 4th byte of a word.
//   word_p1    : assembled word; first byte in [7:0]. Holds until the next word.
//   byte_idx   : index (0..3) of the next byte within the current word.
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   vld_p0,
  input  logic [7:0]             byte_p0,
  output logic                   vld_p1,
  output logic [IMEM_WORD_W-1:0] word_p1,
  output logic [1:0]             byte_idx
);

  // First three bytes of the word, newest at the top.
  logic [23:0] shift_p0;

  // p0 -> p1: the 4th byte completes the word.
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_idx <= 2'd0;
      vld_p1   <= 1'b0;
      word_p1  <= '0;
      shift_p0 <= '0;
    end else begin
      vld_p1 <= 1'b0;
      if (clear) begin
        byte_idx <= 2'd0;
      end else if (vld_p0) begin
        byte_idx <= byte_idx + 2'd1;
        if (byte_idx == 2'd3) begin
          word_p1 <= {byte_p0, shift_p0};
          vld_p1  <= 1'b1;
        end else begin
          shift_p0 <= {byte_p0, shift_p0[23:8]};
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: receives an image (LEN0, LEN1 = word count N,
// little-endian; then 4*N data bytes) and writes it into imem while holding
// the core in reset. The core is released only after a complete image.
// Optional feature macro: LOADER_CHECKSUM_EN -- adds a trailing checksum byte
// (XOR of all data bytes) checked in state CHK before DONE.
// Ports:
//   clk, reset   : clock, synchronous active-high reset.
//   start        : pulse to begin a load (honoured in IDLE, DONE, ERROR).
//   rx_valid/rx_data/rx_ready : byte stream handshake.
//   imem_we/imem_waddr/imem_wdata : imem write port.
//   cpu_reset    : core reset; low only while DONE.
//   busy/done/error : loader status.
//   words_loaded : words written in the current/last load.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   rx_valid,
  input  logic [7:0]             rx_data,
  output logic                   rx_ready,
  output logic                   imem_we,
  output logic [ADDR_W-1:0]      imem_waddr,
  output logic [IMEM_WORD_W-1:0] imem_wdata,
  output logic                   cpu_reset,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [ADDR_W:0]        words_loaded
);

  localparam logic [16:0]   CAP = 17'(2 ** ADDR_W);
  localparam logic [ADDR_W:0] ONE = 1;
`ifdef LOADER_CHECKSUM_EN
  localparam ldr_state_e END_ST = LDR_CHK;
`else
  localparam ldr_state_e END_ST = LDR_DONE;
`endif

  ldr_state_e        state, state_n;
  logic [7:0]        len_lo_q;
  logic [15:0]       len_q;
  logic [ADDR_W:0]   words_q;
  logic              cpu_reset_q;
  logic [1:0]        byte_idx;
  logic              xfer, start_ok, vld_p0, last_word;
  logic [16:0]       len_rx;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        chk_q;
`endif

  assign xfer     = rx_valid & rx_ready;
  assign start_ok = start & ((state == LDR_IDLE) | (state == LDR_DONE) | (state == LDR_ERROR));
  assign vld_p0   = xfer & (state == LDR_DATA);
  assign len_rx   = {1'b0, rx_data, len_lo_q};
  // The 4th byte of word N-1 ends the image.
  assign last_word = (byte_idx == 2'd3) && ((17'(words_q) + 17'd1) == {1'b0, len_q});

  word_assembler u_asm (
    .clk      (clk),
    .reset    (reset),
    .clear    (start_ok),
    .vld_p0   (vld_p0),
    .byte_p0  (rx_data),
    .vld_p1   (imem_we),
    .word_p1  (imem_wdata),
    .byte_idx (byte_idx)
  );

  always_comb begin
    state_n  = state;
    rx_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    case (state)
      LDR_IDLE: if (start) state_n = LDR_LEN0;
      LDR_LEN0: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (rx_valid) state_n = LDR_LEN1;
      end
      LDR_LEN1: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (rx_valid) begin
          if (len_rx == 17'd0)  state_n = END_ST;
          else if (len_rx > CAP) state_n = LDR_ERROR;
          else                  state_n = LDR_DATA;
        end
      end
      LDR_DATA: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (rx_valid && last_word) state_n = END_ST;
      end
`ifdef LOADER_CHECKSUM_EN
      LDR_CHK: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (rx_valid) state_n = (rx_data == chk_q) ? LDR_DONE : LDR_ERROR;
      end
`endif
      LDR_DONE: begin
        done = 1'b1;
        if (start) state_n = LDR_LEN0;
      end
      LDR_ERROR: begin
        error = 1'b1;
        if (start) state_n = LDR_LEN0;
      end
      default: state_n = LDR_IDLE;
    endcase
  end

  // Address and count register on the 4th-byte handshake so they line up
  // with the assembler's write pulse one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= LDR_IDLE;
      len_lo_q    <= '0;
      len_q       <= '0;
      words_q     <= '0;
      imem_waddr  <= '0;
      cpu_reset_q <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
      chk_q       <= '0;
`endif
    end else begin
      state       <= state_n;
      cpu_reset_q <= (state_n != LDR_DONE);
      if (start_ok) words_q <= '0;
      if (xfer && state == LDR_LEN0) len_lo_q <= rx_data;
      if (xfer && state == LDR_LEN1) len_q <= {rx_data, len_lo_q};
      if (vld_p0 && byte_idx == 2'd3) begin
        imem_waddr <= words_q[ADDR_W-1:0];
        words_q    <= words_q + ONE;
      end
`ifdef LOADER_CHECKSUM_EN
      if (start_ok)    chk_q <= '0;
      else if (vld_p0) chk_q <= chk_q ^ rx_data;
`endif
    end
  end

  assign cpu_reset    = reset | cpu_reset_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int ADDR_W = 8;

  logic                   clk = 1'b0;
  logic                   reset, start, rx_valid;
  logic [7:0]             rx_data;
  logic                   rx_ready, imem_we, cpu_reset, busy, done, error;
  logic [ADDR_W-1:0]      imem_waddr;
  logic [IMEM_WORD_W-1:0] imem_wdata;
  logic [ADDR_W:0]        words_loaded;

  int errors = 0;
  int checks = 0;
  logic [7:0]  log_addr [$];
  logic [31:0] log_data [$];
  int base;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  // Write log, sampled on the falling edge.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      log_addr.push_back(imem_waddr);
      log_data.push_back(imem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next falling edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_gap(input logic [7:0] b, input int gap, input logic kick);
    for (int i = 0; i < gap; i++) begin
      start = kick;
      rx_data = 8'hA5;
      tick();
      start = 1'b0;
    end
    send(b);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;

    // 1: reset
    tick(); tick();
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_rx_ready", rx_ready, 0);
    check("rst_we", imem_we, 0);
    check("rst_flags", {busy, done, error}, 0);
    check("rst_words", words_loaded, 0);
    check("rst_waddr", imem_waddr, 0);
    check("rst_wdata", imem_wdata, 0);
    reset = 1'b0;
    tick();

    // 2: two-word image
    pulse_start();
    check("t2_busy", busy, 1);
    check("t2_rx_ready", rx_ready, 1);
    send(8'h02); send(8'h00);
    send(8'h78); send(8'h56); send(8'h34);
    check("t2_no_we_early", imem_we, 0);
    send(8'h12);
    check("t2_we0", imem_we, 1);
    check("t2_addr0", imem_waddr, 0);
    check("t2_data0", imem_wdata, 32'h12345678);
    check("t2_words1", words_loaded, 1);
    send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
    check("t2_we1", imem_we, 1);
    check("t2_addr1", imem_waddr, 1);
    check("t2_data1", imem_wdata, 32'hDEADBEEF);
    check("t2_words2", words_loaded, 2);
`ifdef LOADER_CHECKSUM_EN
    check("t2_chk_busy", busy, 1);
    check("t2_chk_cpu_reset", cpu_reset, 1);
    send(8'h2A);
`endif
    check("t2_done", done, 1);
    check("t2_cpu_run", cpu_reset, 0);
    check("t2_not_busy", busy, 0);
    tick();
    check("t2_we_single", imem_we, 0);
    check("t2_we_count", log_addr.size(), 2);

    // 3: empty image, then oversize image
    pulse_start();
    check("t3_cpu_reset_restart", cpu_reset, 1);
    send(8'h00); send(8'h00);
`ifdef LOADER_CHECKSUM_EN
    send(8'h00);
`endif
    check("t3_done_empty", done, 1);
    check("t3_cpu_run_empty", cpu_reset, 0);
    check("t3_no_we", log_addr.size(), 2);
    pulse_start();
    send(8'h01); send(8'h01);
    check("t3_error", error, 1);
    check("t3_err_cpu_reset", cpu_reset, 1);
    check("t3_err_rx_ready", rx_ready, 0);

    // N == 2**ADDR_W is legal; abort it with reset after 5 bytes
    pulse_start();
    check("t3_err_cleared", error, 0);
    send(8'h00); send(8'h01);
    check("t4_full_accepted", {busy, error}, 2'b10);
    send(8'h11); send(8'h22); send(8'h33);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t4_rst_idle", {busy, done, error, rx_ready}, 0);
    check("t4_rst_cpu_reset", cpu_reset, 1);
    check("t4_rst_no_we", log_addr.size(), 2);
    tick();
    check("t4_rst_cpu_held", cpu_reset, 1);

    // 4: gaps and ignored start pulses
    pulse_start();
    base = log_addr.size();
    send_gap(8'h02, 2, 1'b0); send_gap(8'h00, 1, 1'b1);
    send_gap(8'h78, 3, 1'b1); send_gap(8'h56, 0, 1'b0);
    send_gap(8'h34, 2, 1'b1); send_gap(8'h12, 1, 1'b0);
    send_gap(8'hEF, 4, 1'b1); send_gap(8'hBE, 1, 1'b0);
    send_gap(8'hAD, 2, 1'b1); send_gap(8'hDE, 3, 1'b0);
`ifdef LOADER_CHECKSUM_EN
    send_gap(8'h2A, 2, 1'b0);
`endif
    check("t4_done", done, 1);
    check("t4_words", words_loaded, 2);
    check("t4_count", log_addr.size() - base, 2);
    if (log_addr.size() - base == 2) begin
      check("t4_addr0", log_addr[base], 0);
      check("t4_data0", log_data[base], 32'h12345678);
      check("t4_addr1", log_addr[base+1], 1);
      check("t4_data1", log_data[base+1], 32'hDEADBEEF);
    end

    // 5: reload from DONE with a one-word image
    pulse_start();
    check("t5_cpu_reset", cpu_reset, 1);
    check("t5_words0", words_loaded, 0);
    check("t5_done_drop", done, 0);
    send(8'h01); send(8'h00);
    send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
    check("t5_data", imem_wdata, 32'hDDCCBBAA);
    check("t5_addr", imem_waddr, 0);
    check("t5_words1", words_loaded, 1);
`ifdef LOADER_CHECKSUM_EN
    send(8'h00);
`endif
    check("t5_done", done, 1);

    // 6: checksum byte
    pulse_start();
    send(8'h01); send(8'h00);
    send(8'h78); send(8'h56); send(8'h34); send(8'h12);
`ifdef LOADER_CHECKSUM_EN
    send(8'h08);
    check("t6_done_good", done, 1);
    check("t6_run_good", cpu_reset, 0);
    pulse_start();
    send(8'h01); send(8'h00);
    send(8'h78); send(8'h56); send(8'h34); send(8'h12);
    send(8'h09);
    check("t6_error_bad", error, 1);
    check("t6_cpu_held", cpu_reset, 1);
`else
    check("t6_done", done, 1);
    check("t6_no_ready", rx_ready, 0);
    send(8'h08);
    check("t6_still_done", done, 1);
    check("t6_words_kept", words_loaded, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
